// File: rtl/trb_readout_ctrl.sv
// Trace buffer readout sequencer: drains TRB_DEPTH words from a base address (wrapping) into a
// valid/ready stream, using a 2-entry buffer with read credits to hide the 1-cycle memory latency.
module trb_readout_ctrl #(
   parameter int unsigned TRB_WIDTH = 8,
   parameter int unsigned TRB_DEPTH = 16
) (
   input  logic                         FPGA_CLK_I,
   input  logic                         RST_NI,
   input  logic                         START_I,
   input  logic                         ABORT_I,
   input  logic                         TRG_EVENT_I,
   input  logic [$clog2(TRB_DEPTH)-1:0] BASE_ADDR_I,
   output logic                         RD_EN_O,
   output logic [$clog2(TRB_DEPTH)-1:0] RD_ADDR_O,
   input  logic [TRB_WIDTH-1:0]         RD_DATA_I,
   output logic [TRB_WIDTH-1:0]         DATA_O,
   output logic                         VALID_O,
   input  logic                         READY_I,
   output logic                         LAST_O,
   output logic                         BUSY_O,
   output logic                         DONE_O
);

   localparam int unsigned AW = $clog2(TRB_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] LastCnt = CW'(TRB_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e               r_state;
   state_e               w_state_next;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_issue_cnt;
   logic [CW-1:0]        r_pop_cnt;
   logic                 r_infl;
   logic [1:0]           r_occ;
   logic [TRB_WIDTH-1:0] r_buf0;
   logic [TRB_WIDTH-1:0] r_buf1;

   logic w_pop;
   logic w_push;
   logic w_issue;
   logic w_start;
   logic w_wr_idx;

   assign VALID_O = (r_occ != 2'd0);
   assign w_pop   = VALID_O & READY_I;
   assign w_push  = r_infl;

   // Issue only while buffered + in-flight words, net of this cycle's pop, leave a free slot.
   assign w_issue = (r_state == StRun) & ~ABORT_I &
                    (({1'b0, r_occ} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));

   assign w_start = START_I & TRG_EVENT_I & ~ABORT_I &
                    ((r_state == StIdle) | (r_state == StDone));

   // Slot the returning word lands in once this cycle's pop has shifted the buffer.
   assign w_wr_idx = (r_occ == 2'd2) | ((r_occ == 2'd1) & ~w_pop);

   always_comb begin
      w_state_next = r_state;
      if (ABORT_I) begin
         w_state_next = StIdle;
      end else begin
         case (r_state)
            StIdle, StDone: if (w_start) w_state_next = StRun;
            StRun:          if (w_issue && (r_issue_cnt == LastCnt)) w_state_next = StDrain;
            StDrain:        if (w_pop && (r_pop_cnt == LastCnt)) w_state_next = StDone;
            default:        w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge FPGA_CLK_I) begin
      if (!RST_NI) begin
         r_state     <= StIdle;
         r_rd_ptr    <= '0;
         r_issue_cnt <= '0;
         r_pop_cnt   <= '0;
         r_infl      <= 1'b0;
         r_occ       <= 2'd0;
         r_buf0      <= '0;
         r_buf1      <= '0;
      end else begin
         r_state <= w_state_next;
         if (ABORT_I) begin
            // Flush; a read issued last cycle returns now and is dropped.
            r_occ  <= 2'd0;
            r_infl <= 1'b0;
         end else begin
            r_infl <= w_issue;
            r_occ  <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) r_buf0 <= r_buf1;
            if (w_push) begin
               if (w_wr_idx) r_buf1 <= RD_DATA_I;
               else          r_buf0 <= RD_DATA_I;
            end
            if (w_start) begin
               r_rd_ptr    <= BASE_ADDR_I;
               r_issue_cnt <= '0;
               r_pop_cnt   <= '0;
            end else begin
               if (w_issue) begin
                  r_rd_ptr    <= r_rd_ptr + AW'(1);
                  r_issue_cnt <= r_issue_cnt + CW'(1);
               end
               if (w_pop) r_pop_cnt <= r_pop_cnt + CW'(1);
            end
         end
      end
   end

   assign RD_EN_O   = w_issue;
   assign RD_ADDR_O = r_rd_ptr;
   assign DATA_O    = VALID_O ? r_buf0 : '0;
   assign LAST_O    = VALID_O & (r_pop_cnt == LastCnt);
   assign BUSY_O    = (r_state == StRun) | (r_state == StDrain);
   assign DONE_O    = (r_state == StDone);

endmodule

// File: tb/tb_trb_readout_ctrl.sv
// Directed bench for trb_readout_ctrl: memory holds mem[i]=3*i, streams checked against 3*((base+j)%16).
module tb_trb_readout_ctrl;

   logic       clk = 1'b0;
   logic       RST_NI = 1'b0;
   logic       START_I = 1'b0;
   logic       ABORT_I = 1'b0;
   logic       TRG_EVENT_I = 1'b0;
   logic [3:0] BASE_ADDR_I = 4'd0;
   logic       RD_EN_O;
   logic [3:0] RD_ADDR_O;
   logic [7:0] RD_DATA_I = 8'd0;
   logic [7:0] DATA_O;
   logic       VALID_O;
   logic       READY_I = 1'b1;
   logic       LAST_O;
   logic       BUSY_O;
   logic       DONE_O;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [16];
   logic [7:0] got_data [$];
   logic       got_last [$];
   int         addr_log [$];
   logic [7:0] stall_data [$];
   logic       stall_rden [$];
   logic       stall_valid [$];
   int         done_cyc;
   int         first_valid_cyc;

   always #5 clk = ~clk;

   trb_readout_ctrl #(.TRB_WIDTH(8), .TRB_DEPTH(16)) dut (
      .FPGA_CLK_I (clk),
      .RST_NI     (RST_NI),
      .START_I    (START_I),
      .ABORT_I    (ABORT_I),
      .TRG_EVENT_I(TRG_EVENT_I),
      .BASE_ADDR_I(BASE_ADDR_I),
      .RD_EN_O    (RD_EN_O),
      .RD_ADDR_O  (RD_ADDR_O),
      .RD_DATA_I  (RD_DATA_I),
      .DATA_O     (DATA_O),
      .VALID_O    (VALID_O),
      .READY_I    (READY_I),
      .LAST_O     (LAST_O),
      .BUSY_O     (BUSY_O),
      .DONE_O     (DONE_O)
   );

   always_ff @(posedge clk) if (RD_EN_O) RD_DATA_I <= mem[RD_ADDR_O];

   // mode 0: READY high; 1: READY toggling plus 5-cycle stall at word 3; 2: READY high with
   // extra START pulses while running. k counts edges after the START-accepting edge.
   task automatic collect(input logic [3:0] base, input int mode, input int stop_after);
      int  stall_left;
      bit  stalled;
      got_data.delete(); got_last.delete(); addr_log.delete();
      stall_data.delete(); stall_rden.delete(); stall_valid.delete();
      done_cyc = -1; first_valid_cyc = -1; stall_left = 0; stalled = 0;
      @(negedge clk);
      START_I = 1'b1; TRG_EVENT_I = 1'b1; BASE_ADDR_I = base; READY_I = 1'b1;
      @(negedge clk);
      START_I = 1'b0;
      for (int k = 0; k < 100; k++) begin
         START_I = (mode == 2) && (k == 3 || k == 8);
         if (START_I) BASE_ADDR_I = 4'd9;
         if (mode == 1) begin
            if (!stalled && VALID_O && got_data.size() == 3) begin
               stalled = 1; stall_left = 5;
            end
            if (stall_left > 0) READY_I = 1'b0;
            else                READY_I = (k % 2 == 0);
         end else begin
            READY_I = 1'b1;
         end
         #1;
         if (first_valid_cyc < 0 && VALID_O) first_valid_cyc = k;
         if (done_cyc < 0 && DONE_O) done_cyc = k;
         if (RD_EN_O) addr_log.push_back(int'(RD_ADDR_O));
         if (stall_left > 0) begin
            stall_data.push_back(DATA_O);
            stall_rden.push_back(RD_EN_O);
            stall_valid.push_back(VALID_O);
            stall_left--;
         end
         if (VALID_O && READY_I) begin
            got_data.push_back(DATA_O);
            got_last.push_back(LAST_O);
         end
         if (stop_after > 0 && got_data.size() == stop_after) break;
         if (done_cyc >= 0 && k >= done_cyc + 3) break;
         @(negedge clk);
      end
      START_I = 1'b0;
      READY_I = 1'b1;
   endtask

   task automatic test_reset();
      RST_NI = 1'b0;
      repeat (2) @(negedge clk);
      RST_NI = 1'b1;
      #1;
      checks++; if (RD_EN_O !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", RD_EN_O); end
      checks++; if (RD_ADDR_O !== 4'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", RD_ADDR_O); end
      checks++; if (DATA_O !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", DATA_O); end
      checks++; if (VALID_O !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", VALID_O); end
      checks++; if (LAST_O !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", LAST_O); end
      checks++; if (BUSY_O !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY_O); end
      checks++; if (DONE_O !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE_O); end
   endtask

   task automatic test_stream_ready();
      collect(4'd5, 0, 0);
      checks++; if (got_data.size() !== 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 16; j++) begin
         checks++;
         if (got_data[j] !== 8'(3 * ((5 + j) % 16))) begin
            failures++; $display("FAIL stream_word%0d got=%0d exp=%0d", j, got_data[j], 3 * ((5 + j) % 16));
         end
         checks++;
         if (got_last[j] !== (j == 15)) begin
            failures++; $display("FAIL stream_last%0d got=%b exp=%b", j, got_last[j], (j == 15));
         end
      end
      checks++; if (addr_log.size() !== 16) begin failures++; $display("FAIL stream_issue_count got=%0d exp=16", addr_log.size()); end
      for (int j = 0; j < addr_log.size() && j < 16; j++) begin
         checks++;
         if (addr_log[j] !== (5 + j) % 16) begin
            failures++; $display("FAIL stream_addr%0d got=%0d exp=%0d", j, addr_log[j], (5 + j) % 16);
         end
      end
      checks++; if (first_valid_cyc !== 2) begin failures++; $display("FAIL stream_first_valid got=%0d exp=2", first_valid_cyc); end
      checks++; if (done_cyc !== 18) begin failures++; $display("FAIL stream_done_cycle got=%0d exp=18", done_cyc); end
      checks++; if (BUSY_O !== 1'b0) begin failures++; $display("FAIL stream_busy_after got=%b exp=0", BUSY_O); end
   endtask

   task automatic test_reread();
      collect(4'd15, 0, 0);
      checks++; if (got_data.size() !== 16) begin failures++; $display("FAIL reread_count got=%0d exp=16", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 16; j++) begin
         checks++;
         if (got_data[j] !== 8'(3 * ((15 + j) % 16))) begin
            failures++; $display("FAIL reread_word%0d got=%0d exp=%0d", j, got_data[j], 3 * ((15 + j) % 16));
         end
         checks++;
         if (got_last[j] !== (j == 15)) begin
            failures++; $display("FAIL reread_last%0d got=%b exp=%b", j, got_last[j], (j == 15));
         end
      end
      checks++; if (done_cyc !== 18) begin failures++; $display("FAIL reread_done_cycle got=%0d exp=18", done_cyc); end
   endtask

   task automatic test_no_trigger();
      @(negedge clk); RST_NI = 1'b0;
      @(negedge clk); RST_NI = 1'b1;
      START_I = 1'b1; TRG_EVENT_I = 1'b0; BASE_ADDR_I = 4'd3;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         START_I = 1'b0;
         #1;
         checks++; if (RD_EN_O !== 1'b0) begin failures++; $display("FAIL notrig_rd_en%0d got=%b exp=0", c, RD_EN_O); end
         checks++; if (BUSY_O !== 1'b0) begin failures++; $display("FAIL notrig_busy%0d got=%b exp=0", c, BUSY_O); end
      end
   endtask

   task automatic test_stall();
      collect(4'd5, 1, 0);
      checks++; if (got_data.size() !== 16) begin failures++; $display("FAIL stall_count got=%0d exp=16", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 16; j++) begin
         checks++;
         if (got_data[j] !== 8'(3 * ((5 + j) % 16))) begin
            failures++; $display("FAIL stall_word%0d got=%0d exp=%0d", j, got_data[j], 3 * ((5 + j) % 16));
         end
         checks++;
         if (got_last[j] !== (j == 15)) begin
            failures++; $display("FAIL stall_last%0d got=%b exp=%b", j, got_last[j], (j == 15));
         end
      end
      checks++; if (stall_data.size() !== 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", stall_data.size()); end
      for (int j = 0; j < stall_data.size(); j++) begin
         checks++;
         if (stall_data[j] !== 8'd24 || stall_valid[j] !== 1'b1) begin
            failures++; $display("FAIL stall_hold%0d got=%0d/%b exp=24/1", j, stall_data[j], stall_valid[j]);
         end
         if (j >= 2) begin
            checks++;
            if (stall_rden[j] !== 1'b0) begin failures++; $display("FAIL stall_rd_en%0d got=%b exp=0", j, stall_rden[j]); end
         end
      end
      checks++; if (DONE_O !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", DONE_O); end
   endtask

   task automatic test_abort();
      collect(4'd5, 0, 7);
      checks++; if (got_data.size() !== 7) begin failures++; $display("FAIL abort_pre_count got=%0d exp=7", got_data.size()); end
      @(negedge clk);
      ABORT_I = 1'b1;
      @(negedge clk);
      ABORT_I = 1'b0;
      #1;
      checks++; if (VALID_O !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", VALID_O); end
      checks++; if (BUSY_O !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", BUSY_O); end
      checks++; if (DONE_O !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", DONE_O); end
      checks++; if (RD_EN_O !== 1'b0) begin failures++; $display("FAIL abort_rd_en got=%b exp=0", RD_EN_O); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if (VALID_O !== 1'b0) begin failures++; $display("FAIL abort_idle_valid%0d got=%b exp=0", c, VALID_O); end
      end
      collect(4'd0, 0, 0);
      checks++; if (got_data.size() !== 16) begin failures++; $display("FAIL abort_restart_count got=%0d exp=16", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 16; j++) begin
         checks++;
         if (got_data[j] !== 8'(3 * j)) begin
            failures++; $display("FAIL abort_restart_word%0d got=%0d exp=%0d", j, got_data[j], 3 * j);
         end
      end
      checks++; if (first_valid_cyc !== 2) begin failures++; $display("FAIL abort_restart_first_valid got=%0d exp=2", first_valid_cyc); end
      checks++; if (done_cyc !== 18) begin failures++; $display("FAIL abort_restart_done got=%0d exp=18", done_cyc); end
   endtask

   task automatic test_reset_mid_drain();
      collect(4'd5, 2, 15);
      checks++; if (got_data.size() !== 15) begin failures++; $display("FAIL middrain_count got=%0d exp=15", got_data.size()); end
      for (int j = 0; j < got_data.size() && j < 15; j++) begin
         checks++;
         if (got_data[j] !== 8'(3 * ((5 + j) % 16))) begin
            failures++; $display("FAIL middrain_word%0d got=%0d exp=%0d", j, got_data[j], 3 * ((5 + j) % 16));
         end
      end
      @(negedge clk); #1;
      checks++; if (BUSY_O !== 1'b1 || RD_EN_O !== 1'b0) begin
         failures++; $display("FAIL middrain_state busy/rd_en got=%b/%b exp=1/0", BUSY_O, RD_EN_O);
      end
      RST_NI = 1'b0;
      @(negedge clk);
      RST_NI = 1'b1;
      #1;
      checks++;
      if ({RD_EN_O, RD_ADDR_O, DATA_O, VALID_O, LAST_O, BUSY_O, DONE_O} !== 17'd0) begin
         failures++;
         $display("FAIL middrain_reset got rd_en=%b addr=%0d data=%0d valid=%b last=%b busy=%b done=%b exp all 0",
                  RD_EN_O, RD_ADDR_O, DATA_O, VALID_O, LAST_O, BUSY_O, DONE_O);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (VALID_O !== 1'b0 || BUSY_O !== 1'b0) begin
         failures++; $display("FAIL middrain_idle valid/busy got=%b/%b exp=0/0", VALID_O, BUSY_O);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(3 * i);
      test_reset();
      test_stream_ready();
      test_reread();
      test_no_trigger();
      test_stall();
      test_abort();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trb_readout_ctrl.md
Name: trb_readout_ctrl

Overview:
- Host-side sequencer that drains the trace buffer memory once the FPGA-side capture has finished.
- Issues reads on the memory's host read port, starting at a base address and wrapping modulo TRB_DEPTH, so the host receives TRB_DEPTH words in chronological order.
- Output is a valid/ready word stream with a LAST flag, which feeds the host serializer/interface.
- A 2-entry output buffer with read-credit accounting absorbs the 1-cycle memory read latency and sustains 1 word/cycle under continuous READY.

Parameters:
TRB_WIDTH, 8, data word width in bits (matches trace buffer memory width).
TRB_DEPTH, 16, number of words in trace buffer; power of two, >= 2.

Ports:
FPGA_CLK_I  in  1  clock; all logic rising-edge.
RST_NI  in  1  synchronous active-low reset.
START_I  in  1  pulse; request a readout.
ABORT_I  in  1  pulse; cancel readout, return to idle.
TRG_EVENT_I  in  1  capture-complete flag from trace buffer status.
BASE_ADDR_I  in  $clog2(TRB_DEPTH)  address of oldest word; sampled on accepted START_I.
RD_EN_O  out  1  memory read enable.
RD_ADDR_O  out  $clog2(TRB_DEPTH)  memory read address.
RD_DATA_I  in  TRB_WIDTH  memory read data, valid the cycle after RD_EN_O.
DATA_O  out  TRB_WIDTH  stream data.
VALID_O  out  1  stream valid.
READY_I  in  1  stream ready.
LAST_O  out  1  marks final word (qualified by VALID_O).
BUSY_O  out  1  high in RUN or DRAIN.
DONE_O  out  1  high in DONE.

Behaviour:
- Reset (RST_NI=0 at a clock edge):
  - State goes to IDLE; buffer is flushed; counters are zero.
  - Outputs: RD_EN_O=0, RD_ADDR_O=0, DATA_O=0, VALID_O=0, LAST_O=0, BUSY_O=0, DONE_O=0.
  - Reset overrides all other inputs, including mid-readout.
- States:
  - IDLE -> RUN: on START_I=1 and TRG_EVENT_I=1. Latch BASE_ADDR_I into rd_ptr; clear issue_cnt and pop_cnt.
  - START_I with TRG_EVENT_I=0 is ignored; the block stays in IDLE.
  - RUN -> DRAIN: in the cycle the TRB_DEPTH-th read is issued (issue_cnt reaches TRB_DEPTH).
  - DRAIN -> DONE: in the cycle the last word is popped (pop_cnt reaches TRB_DEPTH).
  - DONE -> RUN: on START_I=1 and TRG_EVENT_I=1 (re-read), with the same latch and clear as IDLE -> RUN.
  - START_I in RUN or DRAIN is ignored.
  - ABORT_I=1 in any state -> IDLE next cycle. The buffer is flushed. An in-flight read returning in the following cycle is discarded. VALID_O=0 from the cycle after ABORT_I.
  - ABORT_I takes priority over START_I in the same cycle.
- Read issue:
  - Define occ = buffered words (0..2), infl = 1 if a read was issued last cycle, pop = VALID_O & READY_I.
  - RD_EN_O=1 in RUN when (occ + infl - pop) < 2.
  - RD_EN_O is combinational from state and counters.
  - RD_ADDR_O = rd_ptr. On issue, rd_ptr <= (rd_ptr+1) mod TRB_DEPTH and issue_cnt increments.
  - Exactly TRB_DEPTH reads are issued per readout. The address wraps from TRB_DEPTH-1 to 0.
- Buffer:
  - RD_DATA_I is pushed the cycle after an issue.
  - Push and pop can occur in the same cycle; the buffer never overflows (guaranteed by the credit rule).
  - DATA_O/VALID_O are driven from the head entry. VALID_O=1 whenever occ>0.
- Handshake:
  - DATA_O and LAST_O are held stable while VALID_O=1 and READY_I=0.
  - VALID_O never deasserts without a pop, except on ABORT_I or reset.
  - LAST_O=1 only on the word with pop_cnt = TRB_DEPTH-1.
- Latency and throughput:
  - First read is issued the cycle after START_I is accepted.
  - First VALID_O occurs 2 cycles after START_I.
  - With READY_I held high: one word/cycle; DONE_O asserts TRB_DEPTH+2 cycles after START_I.
- Counters: issue_cnt and pop_cnt are $clog2(TRB_DEPTH)+1 bits wide to represent TRB_DEPTH.
- TRG_EVENT_I dropping during RUN or DRAIN has no effect.

Test Plan:
- Memory mem[i]=3*i; BASE_ADDR_I=5; START_I with TRG_EVENT_I=1; READY_I=1 -> expected stream:
  - 16 words: 15,18,…,45, then 0,3,…,12.
  - Addresses wrap 15->0.
  - LAST_O only on word 12.
  - DONE_O asserts 18 cycles after START_I.
- Same stimulus with READY_I toggling 1/0 each cycle, plus a 5-cycle READY_I=0 stall at word 3 -> identical 16-word sequence, no drops or duplicates, DATA_O stable during the stall, RD_EN_O=0 while the buffer is full.
- START_I with TRG_EVENT_I=0 -> remains IDLE; RD_EN_O=0, BUSY_O=0 for 20 cycles.
- ABORT_I after 7 words are popped -> VALID_O=0 next cycle, state IDLE, BUSY_O=0. A new START_I with BASE_ADDR_I=0 then streams 0,3,…,45 cleanly, with no stale word first.
- RST_NI=0 for 1 cycle mid-DRAIN -> all outputs zero next cycle; START_I pulses arriving during RUN are ignored (single 16-word stream).
- In DONE, START_I with BASE_ADDR_I=15 -> re-read beginning 45, 0, 3, …, ending 42 with LAST_O.
